// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM state
// encodings, stream framing constants and the running checksum helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four big-endian stream bytes into a 32-bit instruction word and
// flags the completing byte; clear discards any partially assembled word.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  byte_cnt_r;
    // Only the first three bytes need storing; the fourth is taken live.
    logic [23:0] shift_r;

    // byte counter and MSB-first shift register
    always_ff @(posedge clk) begin
        if (clear) begin
            byte_cnt_r <= 2'd0;
            shift_r    <= 24'd0;
        end else if (byte_en) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            shift_r    <= {shift_r[15:0], byte_in};
        end else begin
            byte_cnt_r <= byte_cnt_r;
            shift_r    <= shift_r;
        end
    end

    assign word_valid = byte_en && (byte_cnt_r == 2'(WORD_BYTES - 1));
    assign word       = {shift_r, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a length-prefixed byte stream,
// writes sequential words and releases the CPU once the image is complete.
// Optional trailing XOR checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CHK;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t            state_r, next_state_s;
    logic [15:0]       count_r, word_idx_r, len_s;
    logic              in_ready_s, xfer_s, clear_s, byte_en_s;
    logic              word_valid_s, last_word_s;
    logic [31:0]       word_s;
    logic              wren_r, cpu_rst_r, done_r, error_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [31:0]       wdata_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        chk_r;
`endif

    assign xfer_s      = in_valid && in_ready_s;
    assign clear_s     = rst || (state_r == LEN_LO);
    assign byte_en_s   = xfer_s && (state_r == DATA);
    assign len_s       = {count_r[15:8], in_data};
    assign last_word_s = word_valid_s && ((word_idx_r + 16'd1) == count_r);

    word_assembler u_word_assembler (
        .clk        (clk),
        .clear      (clear_s),
        .byte_en    (byte_en_s),
        .byte_in    (in_data),
        .word_valid (word_valid_s),
        .word       (word_s)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LEN_HI;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            LEN_HI: begin
                if (xfer_s) next_state_s = LEN_LO;
                else        next_state_s = LEN_HI;
            end
            LEN_LO: begin
                if (!xfer_s)                         next_state_s = LEN_LO;
                else if ({1'b0, len_s} > MAX_WORDS)  next_state_s = ERR;
                else if (len_s == 16'd0)             next_state_s = AFTER_DATA;
                else                                 next_state_s = DATA;
            end
            DATA: begin
                if (last_word_s) next_state_s = AFTER_DATA;
                else             next_state_s = DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (!xfer_s)               next_state_s = CHK;
                else if (in_data == chk_r) next_state_s = DONE;
                else                       next_state_s = ERR;
            end
`endif
            DONE:    next_state_s = DONE;
            ERR:     next_state_s = ERR;
            default: next_state_s = LEN_HI;
        endcase
    end

    // output decode: readiness depends on the state register alone
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            LEN_HI, LEN_LO, DATA, CHK: in_ready_s = 1'b1;
            default:                   in_ready_s = 1'b0;
        endcase
    end

    // word count capture and word index
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= 16'd0;
            word_idx_r <= 16'd0;
        end else begin
            if (xfer_s && (state_r == LEN_HI)) begin
                count_r <= {in_data, count_r[7:0]};
            end else if (xfer_s && (state_r == LEN_LO)) begin
                count_r <= len_s;
            end else begin
                count_r <= count_r;
            end
            if (state_r == LEN_LO) begin
                word_idx_r <= 16'd0;
            end else if (word_valid_s) begin
                word_idx_r <= word_idx_r + 16'd1;
            end else begin
                word_idx_r <= word_idx_r;
            end
        end
    end

    // write port registers; address/data hold between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            wren_r  <= 1'b0;
            waddr_r <= '0;
            wdata_r <= 32'd0;
        end else begin
            wren_r <= word_valid_s;
            if (word_valid_s) begin
                waddr_r <= word_idx_r[ADDR_W-1:0];
                wdata_r <= word_s;
            end else begin
                waddr_r <= waddr_r;
                wdata_r <= wdata_r;
            end
        end
    end

    // status registers; the CPU is released one cycle after a completing write
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst_r <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            cpu_rst_r <= !((state_r == DONE) || ((next_state_s == DONE) && !word_valid_s));
            done_r    <= (next_state_s == DONE);
            error_r   <= (next_state_s == ERR);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // running XOR over payload bytes
    always_ff @(posedge clk) begin
        if (clear_s) begin
            chk_r <= 8'd0;
        end else if (byte_en_s) begin
            chk_r <= chk_update(chk_r, in_data);
        end else begin
            chk_r <= chk_r;
        end
    end
`endif

    assign in_ready   = in_ready_s;
    assign imem_wren  = wren_r;
    assign imem_waddr = waddr_r;
    assign imem_wdata = wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized streams
// checked against a stream-level reference model of the loader.
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;
    localparam int BUDGET    = 20000;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_data = 8'd0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fall_cyc = -1;
    int hs_q[$];
    int wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int wr_cyc_q[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_wren  (imem_wren),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: handshakes, write strobes and CPU release, sampled mid-cycle
    always @(negedge clk) begin
        if (in_valid && in_ready) hs_q.push_back(cyc);
        if (imem_wren) begin
            wr_addr_q.push_back(int'(imem_waddr));
            wr_data_q.push_back(imem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (!cpu_rst && fall_cyc < 0) fall_cyc = cyc;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'd0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_wren", 64'(imem_wren), 64'd0);
        check_eq("rst_waddr", 64'(imem_waddr), 64'd0);
        check_eq("rst_wdata", 64'(imem_wdata), 64'd0);
        check_eq("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        rst = 1'b0;
        hs_q = {};
        wr_addr_q = {};
        wr_data_q = {};
        wr_cyc_q = {};
        fall_cyc = -1;
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random valid
    task automatic drive(input bq_t s, input int mode);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < s.size() && guard < BUDGET) begin
            if (!in_ready) break;
            if (mode == 0)      in_valid = 1'b1;
            else if (mode == 1) in_valid = (guard % 2 == 0);
            else                in_valid = 1'($urandom_range(0, 1));
            in_data = s[idx];
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= BUDGET) check_eq("drive_budget", 64'(guard), 64'd0);
    endtask

    task automatic make_stream(input int n, input bit bad, output bq_t s);
        logic [7:0] x;
        logic [7:0] b;
        s = {};
        x = 8'h00;
        s.push_back(n[15:8]);
        s.push_back(n[7:0]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            s.push_back(b);
            x ^= b;
        end
        if (bad) x = ~x;
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(x);
`endif
    endtask

    task automatic run_case(input string tag, input bq_t s, input int mode);
        int n, exp_w, nb, exp_fall;
        bit ok;
        logic [7:0] x;
        logic [31:0] w;
        do_reset();
        drive(s, mode);
        repeat (6) @(posedge clk);
        #1;
        n = int'({s[0], s[1]});
        x = 8'h00;
        exp_w = (n > MAX_WORDS) ? 0 : n;
        for (int i = 0; i < 4 * exp_w; i++) x ^= s[2 + i];
`ifdef IMEM_LOADER_CHECKSUM_EN
        ok = (n <= MAX_WORDS) && (s[2 + 4 * exp_w] == x);
        nb = (n > MAX_WORDS) ? 2 : 3 + 4 * n;
`else
        ok = (n <= MAX_WORDS);
        nb = (n > MAX_WORDS) ? 2 : 2 + 4 * n;
`endif
        check_eq({tag, "_nwrites"}, 64'(wr_addr_q.size()), 64'(exp_w));
        check_eq({tag, "_nbytes"}, 64'(hs_q.size()), 64'(nb));
        for (int i = 0; i < exp_w && i < wr_addr_q.size(); i++) begin
            w = {s[2 + 4 * i], s[3 + 4 * i], s[4 + 4 * i], s[5 + 4 * i]};
            check_eq({tag, "_waddr"}, 64'(wr_addr_q[i]), 64'(i));
            check_eq({tag, "_wdata"}, 64'(wr_data_q[i]), 64'(w));
            if (5 + 4 * i < hs_q.size())
                check_eq({tag, "_wcyc"}, 64'(wr_cyc_q[i]), 64'(hs_q[5 + 4 * i] + 1));
        end
        check_eq({tag, "_done"}, 64'(done), 64'(ok));
        check_eq({tag, "_error"}, 64'(error), 64'(!ok));
        check_eq({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(!ok));
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        if (hs_q.size() >= nb) begin
            if (!ok) exp_fall = -1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            else exp_fall = hs_q[nb - 1] + 1;
`else
            else if (n == 0) exp_fall = hs_q[1] + 1;
            else exp_fall = hs_q[nb - 1] + 2;
`endif
            check_eq({tag, "_fall_cyc"}, 64'(fall_cyc), 64'(exp_fall));
        end
    endtask

    initial begin
        bq_t s;
        do_reset();

        s = {8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0D};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h24 ^ 8'h08 ^ 8'h05 ^ 8'h0D);
`endif
        run_case("two_words", s, 0);
        run_case("two_words_toggle", s, 1);

        s = {8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_case("overflow", s, 0);

        s = {8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        run_case("empty", s, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        s = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        run_case("chk_good", s, 0);
        s = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        run_case("chk_bad", s, 0);
`endif

        // abandon a stream mid-word, then load a fresh image
        do_reset();
        s = {8'h00, 8'h01, 8'h12, 8'h34};
        drive(s, 0);
        s = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
        run_case("restart", s, 0);

        make_stream(MAX_WORDS, 1'b0, s);
        run_case("full", s, 0);
        make_stream(MAX_WORDS + 1, 1'b0, s);
        run_case("full_plus1", s, 2);

        for (int k = 0; k < 6; k++) begin
            make_stream(int'($urandom_range(0, 9)), ($urandom_range(0, 3) == 0), s);
            run_case("rand", s, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
